// File: rtl/frame_buffer_scheduler_if.sv
// Bundles the writer, reader and frame-RAM signals of the frame buffer scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface frame_buffer_scheduler_if #(
  parameter int unsigned CNT_W = 17
) ();
  logic             wr_valid;
  logic             wr_sof;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             rd_req;
  logic             rd_gnt;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_eof;
  logic             frame_avail;
  logic             frame_done;
  logic             mem_en;
  logic             mem_we;
  logic [CNT_W:0]   mem_addr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;

  modport master (
    output wr_valid, wr_sof, wr_data, rd_req, mem_rdata,
    input  wr_ready, rd_gnt, rd_valid, rd_data, rd_eof, frame_avail, frame_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_sof, wr_data, rd_req, mem_rdata,
    output wr_ready, rd_gnt, rd_valid, rd_data, rd_eof, frame_avail, frame_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong frame buffer scheduler: shares one single-port frame RAM between a pixel writer
// and a scan-out reader with per-cycle round-robin arbitration.
module frame_buffer_scheduler #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned CNT_W      = 17
) (
  input logic                     clk,
  input logic                     reset,
  frame_buffer_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(IMG_WIDTH * IMG_HEIGHT - 1);

  typedef enum logic [1:0] {WIdle, WFill, WWait} wr_state_e;
  typedef enum logic {GrantRead = 1'b0, GrantWrite = 1'b1} grant_e;

  wr_state_e        r_state, w_state_next;
  grant_e           r_last;
  logic             r_wr_bank, r_rd_bank;
  logic [1:0]       r_full, w_full_next;
  logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt, w_wr_idx;
  logic             r_rd_valid, r_rd_eof, r_frame_done;
  logic             w_rd_want, w_wr_want, w_wr_gnt, w_rd_gnt, w_wr_ready;
  logic             w_wr_last, w_rd_last, w_other_free, w_flip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= WIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      WIdle:   if (w_wr_gnt) w_state_next = WFill;
      WFill:   if (w_wr_last) w_state_next = w_other_free ? WIdle : WWait;
      WWait:   if (w_other_free) w_state_next = WIdle;
      default: w_state_next = WIdle;
    endcase
  end

  // In W_IDLE a sof that loses arbitration is held off rather than silently dropped.
  always_comb begin
    w_rd_want  = bus.rd_req && r_full[r_rd_bank];
    w_wr_want  = 1'b0;
    w_wr_ready = 1'b0;
    unique case (r_state)
      WIdle: begin
        w_wr_want  = reset && bus.wr_valid && bus.wr_sof;
        w_wr_ready = reset && !(bus.wr_sof && w_rd_want && r_last == GrantWrite);
      end
      WFill: begin
        w_wr_want  = bus.wr_valid;
        w_wr_ready = !(w_rd_want && r_last == GrantWrite);
      end
      default: ;
    endcase
    w_wr_gnt = w_wr_want && !(w_rd_want && r_last == GrantWrite);
    w_rd_gnt = w_rd_want && !(w_wr_want && r_last == GrantRead);
  end

  assign w_wr_idx  = bus.wr_sof ? '0 : r_wr_cnt;
  assign w_wr_last = w_wr_gnt && (r_state == WFill) && !bus.wr_sof && (r_wr_cnt == LastIdx);
  assign w_rd_last = w_rd_gnt && (r_rd_cnt == LastIdx);
  // The reader finishing the other bank this cycle frees it at the same edge.
  assign w_other_free = !r_full[~r_wr_bank] || (w_rd_last && (r_rd_bank != r_wr_bank));
  assign w_flip = (r_state != WIdle) && (w_state_next == WIdle);

  always_comb begin
    w_full_next = r_full;
    if (w_wr_last) w_full_next[r_wr_bank] = 1'b1;
    if (w_rd_last) w_full_next[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last       <= GrantRead;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_full       <= 2'b00;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_eof     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_valid   <= w_rd_gnt;
      r_rd_eof     <= w_rd_last;
      r_frame_done <= w_wr_last;
      r_full       <= w_full_next;
      if (w_wr_gnt)      r_last <= GrantWrite;
      else if (w_rd_gnt) r_last <= GrantRead;
      if (w_wr_gnt) begin
        if (bus.wr_sof)     r_wr_cnt <= CNT_W'(1);
        else if (w_wr_last) r_wr_cnt <= '0;
        else                r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (w_flip) r_wr_bank <= ~r_wr_bank;
      if (w_rd_gnt) r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
      if (w_rd_last) r_rd_bank <= ~r_rd_bank;
    end
  end

  assign bus.wr_ready    = w_wr_ready;
  assign bus.rd_gnt      = w_rd_gnt;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_data     = r_rd_valid ? bus.mem_rdata : 8'h00;
  assign bus.rd_eof      = r_rd_eof;
  assign bus.frame_avail = r_full[r_rd_bank];
  assign bus.frame_done  = r_frame_done;
  assign bus.mem_en      = w_wr_gnt || w_rd_gnt;
  assign bus.mem_we      = w_wr_gnt;
  assign bus.mem_addr    = w_wr_gnt ? {r_wr_bank, w_wr_idx} :
                           (w_rd_gnt ? {r_rd_bank, r_rd_cnt} : '0);
  assign bus.mem_wdata   = w_wr_gnt ? bus.wr_data : 8'h00;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler with a 4x2 image and a behavioural frame RAM.
module tb_frame_buffer_scheduler;

  typedef struct packed {
    logic       wr_ready;
    logic       rd_gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_eof;
    logic       frame_avail;
    logic       frame_done;
    logic       mem_en;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
  } outs_t;

  typedef struct {
    logic       wv;
    logic       ws;
    logic [7:0] wd;
    logic       rq;
    outs_t      exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  int    n_checks = 0;
  int    n_errors = 0;
  vec_t  vecs[$];
  outs_t w_outs;
  logic [7:0] ram [16];

  frame_buffer_scheduler_if #(.CNT_W(3)) bus ();

  frame_buffer_scheduler #(
    .IMG_WIDTH (4),
    .IMG_HEIGHT(2),
    .CNT_W     (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  assign w_outs = {bus.wr_ready, bus.rd_gnt, bus.rd_valid, bus.rd_data, bus.rd_eof,
                   bus.frame_avail, bus.frame_done, bus.mem_en, bus.mem_we, bus.mem_addr,
                   bus.mem_wdata};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic ws, input logic [7:0] wd, input logic rq);
    @(negedge clk);
    bus.wr_valid = wv;
    bus.wr_sof   = ws;
    bus.wr_data  = wd;
    bus.rd_req   = rq;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_sof   = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_req   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(w_outs), 64'(0));
    reset = 1'b1;
  endtask

  task automatic add(input logic wv, input logic ws, input logic [7:0] wd, input logic rq,
                     input logic rdy, input logic gnt, input logic rv, input logic [7:0] rdat,
                     input logic eof, input logic av, input logic dn, input logic en,
                     input logic we, input logic [3:0] addr, input logic [7:0] wdat);
    vec_t v;
    v.wv = wv; v.ws = ws; v.wd = wd; v.rq = rq;
    v.exp.wr_ready = rdy;  v.exp.rd_gnt = gnt;      v.exp.rd_valid = rv;
    v.exp.rd_data  = rdat; v.exp.rd_eof = eof;      v.exp.frame_avail = av;
    v.exp.frame_done = dn; v.exp.mem_en = en;       v.exp.mem_we = we;
    v.exp.mem_addr = addr; v.exp.mem_wdata = wdat;
    vecs.push_back(v);
  endtask

  // Writes one full frame (sof + 7 pixels) and checks the completion pulse afterwards.
  task automatic write_frame(input logic [7:0] base, input logic bank);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, base + 8'(i), 1'b0);
      chk("wr_frame_access", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
          {1'b1, 1'b1, bank, 3'(i), base + 8'(i)});
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("wr_frame_done", {bus.frame_done, bus.frame_avail}, 2'b11);
  endtask

  initial begin
    reset = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_sof   = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_req   = 1'b0;

    // Write one frame, read it back, then non-sof pixels in idle.
    add(1, 1, 8'h10, 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 4'd0, 8'h10);
    for (int k = 1; k < 8; k++)
      add(1, 0, 8'h10 + 8'(k), 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 4'(k), 8'h10 + 8'(k));
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 4'd0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 1, 0, 1, 0, 4'd0, 8'h00);
    for (int k = 1; k < 8; k++)
      add(0, 0, 8'h00, 1, 1, 1, 1, 8'h10 + 8'(k - 1), 0, 1, 0, 1, 0, 4'(k), 8'h00);
    add(0, 0, 8'h00, 1, 1, 0, 1, 8'h17, 1, 0, 0, 0, 0, 4'd0, 8'h00);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    add(1, 0, 8'hAA, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    add(1, 0, 8'hAA, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00);

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].wv, vecs[i].ws, vecs[i].wd, vecs[i].rq);
      if (w_outs !== vecs[i].exp) begin
        n_errors++;
        $display("FAIL vec%0d: got %h expected %h", i, w_outs, vecs[i].exp);
      end
      n_checks++;
    end

    // Round-robin: both sides request every cycle after a lone read.
    do_reset();
    write_frame(8'h10, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rr_lone_read", {bus.rd_gnt, bus.mem_addr}, {1'b1, 4'd0});
    begin
      int wj;
      logic ew;
      logic [3:0] ea;
      wj = 0;
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, wj == 0, 8'h20 + 8'(wj), 1'b1);
        ew = (i % 2) == 0;
        ea = ew ? 4'(8 + i / 2) : 4'((i + 1) / 2);
        chk("rr_alternate", {bus.rd_gnt, bus.mem_we, bus.mem_en, bus.wr_ready, bus.mem_addr,
                             bus.mem_wdata},
            {!ew, ew, 1'b1, ew, ea, ew ? 8'h20 + 8'(i / 2) : 8'h00});
        if (bus.wr_ready) wj++;
      end
    end

    // Both banks full: writer waits until the reader releases bank 0.
    do_reset();
    write_frame(8'h30, 1'b0);
    write_frame(8'h40, 1'b1);
    repeat (2) begin
      drive(1'b1, 1'b1, 8'h50, 1'b0);
      chk("wait_held", {bus.wr_ready, bus.mem_en}, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'h50, 1'b1);
      chk("wait_read", {bus.rd_gnt, bus.wr_ready, bus.mem_addr}, {1'b1, 1'b0, 4'(i)});
      if (i > 0) chk("wait_rdata", bus.rd_data, 8'h30 + 8'(i - 1));
    end
    drive(1'b1, 1'b1, 8'h50, 1'b1);
    chk("wait_release", {bus.wr_ready, bus.mem_we, bus.mem_addr, bus.rd_gnt, bus.rd_data,
                         bus.rd_eof, bus.frame_avail},
        {1'b1, 1'b1, 4'd0, 1'b0, 8'h37, 1'b1, 1'b1});

    // Mid-frame sof restarts the same bank.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 8'h60 + 8'(i), 1'b0);
    drive(1'b1, 1'b1, 8'h70, 1'b0);
    chk("sof_restart", {bus.mem_we, bus.mem_addr, bus.frame_done}, {1'b1, 4'd0, 1'b0});
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'h70 + 8'(i), 1'b0);
      chk("sof_refill", {bus.mem_we, bus.mem_addr, bus.frame_done}, {1'b1, 4'(i), 1'b0});
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("sof_done", {bus.frame_done, bus.frame_avail}, 2'b11);

    // Asynchronous reset while a read is in flight.
    do_reset();
    write_frame(8'h80, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8'h55, 1'b1);
    chk("pre_reset_read", {bus.rd_valid, bus.rd_data}, {1'b1, 8'h83});
    #1 reset = 1'b0;
    #1 chk("async_reset", 64'(w_outs), 64'(0));
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_sof   = 1'b0;
    bus.rd_req   = 1'b0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_reset", {bus.frame_avail, bus.rd_gnt, bus.wr_ready, bus.rd_valid}, 4'b0010);
    drive(1'b1, 1'b1, 8'h66, 1'b0);
    chk("post_reset_write", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 4'd0, 8'h66});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
